// File: rtl/multicycle_controller.sv
// Control FSM for the multi-cycle RV32I datapath: sequences fetch/decode/execute/
// writeback, decodes ALU operations, halts on illegal opcodes, counts retirements.
module multicycle_controller #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic [2:0]       func3,
    input  logic [6:0]       func7,
    input  logic             zero,
    input  logic             sign,
    output logic             PCWrite,
    output logic             AdrSrc,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             RegWrite,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [3:0]       ALUControl,
    output logic [2:0]       ImmSrc,
    output logic             halt,
    output logic [CNT_W-1:0] instret
);

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
        S_EXECI, S_ALUWB, S_BRANCH, S_JALRADR, S_JAL, S_LUI, S_ILLEGAL
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             retire;
    logic             unused_func7;

    assign unused_func7 = ^{func7[6], func7[4:0]};

    // SUB is only reachable from register-register ops with func7[5] set
    function automatic logic [3:0] alu_dec(input logic [2:0] f3, input logic f7b5,
                                           input logic rtype);
        case (f3)
            3'b000:  alu_dec = (rtype && f7b5) ? ALU_SUB : ALU_ADD;
            3'b111:  alu_dec = ALU_AND;
            3'b110:  alu_dec = ALU_OR;
            3'b100:  alu_dec = ALU_XOR;
            3'b010:  alu_dec = ALU_SLT;
            3'b011:  alu_dec = ALU_SLTU;
            default: alu_dec = ALU_ADD;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_FETCH;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_BR:        state_d = S_BRANCH;
                    OP_JAL:       state_d = S_JAL;
                    OP_JALR:      state_d = S_JALRADR;
                    OP_LUI:       state_d = S_LUI;
                    default:      state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR:   state_d = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = S_MEMWB;
            S_EXECR,
            S_EXECI,
            S_JAL:      state_d = S_ALUWB;
            S_JALRADR:  state_d = S_JAL;
            S_MEMWB,
            S_MEMWRITE,
            S_ALUWB,
            S_BRANCH,
            S_LUI:      state_d = S_FETCH;
            S_ILLEGAL:  state_d = S_ILLEGAL;
            default:    state_d = S_FETCH;
        endcase
    end

    assign retire    = (state_q == S_MEMWB) || (state_q == S_MEMWRITE) ||
                       (state_q == S_ALUWB) || (state_q == S_BRANCH) || (state_q == S_LUI);
    assign instret_d = instret_q + CNT_W'(retire);
    assign instret   = instret_q;
    assign halt      = (state_q == S_ILLEGAL);

    always_comb begin
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUControl = ALU_ADD;
        ImmSrc     = IMM_I;
        case (state_q)
            S_FETCH: begin
                IRWrite   = 1'b1;
                PCWrite   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                ImmSrc  = (opcode == OP_JAL) ? IMM_J : IMM_B;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ImmSrc  = (opcode == OP_LW) ? IMM_I : IMM_S;
            end
            S_MEMREAD:  AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA    = 2'b10;
                ALUControl = alu_dec(func3, func7[5], 1'b1);
            end
            S_EXECI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUControl = alu_dec(func3, func7[5], 1'b0);
            end
            S_ALUWB:    RegWrite = 1'b1;
            S_BRANCH: begin
                ALUSrcA    = 2'b10;
                ALUControl = ALU_SUB;
                case (func3)
                    3'b000:  PCWrite = zero;
                    3'b001:  PCWrite = ~zero;
                    3'b100:  PCWrite = sign;
                    3'b101:  PCWrite = ~sign;
                    default: PCWrite = 1'b0;
                endcase
            end
            S_JALRADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_JAL: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
            end
            S_LUI: begin
                ImmSrc    = IMM_U;
                ResultSrc = 2'b11;
                RegWrite  = 1'b1;
            end
            default: ;
        endcase
        // Reset holds the FSM in FETCH; its write strobes must not reach the datapath
        if (!rst) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            RegWrite = 1'b0;
            MemWrite = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench for multicycle_controller: each instruction's expected per-cycle
// control words are built from an instruction-level model and compared every cycle.
module tb_multicycle_controller;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [6:0]       opcode;
    logic [2:0]       func3;
    logic [6:0]       func7;
    logic             zero, sign;
    logic             PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, halt;
    logic [1:0]       ResultSrc, ALUSrcA, ALUSrcB;
    logic [3:0]       ALUControl;
    logic [2:0]       ImmSrc;
    logic [CNT_W-1:0] instret;
    logic [17:0]      ctrl;

    int n_checks = 0;
    int n_fail   = 0;
    int model_cnt = 0;

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                           IT = 7'b0010011, BR = 7'b1100011, JAL = 7'b1101111,
                           JALR = 7'b1100111, LUI = 7'b0110111;

    multicycle_controller #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .func7(func7),
        .zero(zero), .sign(sign), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUControl(ALUControl), .ImmSrc(ImmSrc), .halt(halt), .instret(instret)
    );

    always #5 clk = ~clk;

    assign ctrl = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                   ALUSrcA, ALUSrcB, ALUControl, ImmSrc};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [17:0] cw(input bit pcw, input bit adr, input bit mw,
                                       input bit irw, input bit rw, input int rs,
                                       input int sa, input int sb, input int alu,
                                       input int imm);
        cw = {pcw, adr, mw, irw, rw, rs[1:0], sa[1:0], sb[1:0], alu[3:0], imm[2:0]};
    endfunction

    function automatic int alu_of(input logic [2:0] f3, input logic [6:0] f7, input bit rtype);
        case (f3)
            3'd0:    return (rtype && f7[5]) ? 1 : 0;
            3'd7:    return 2;
            3'd6:    return 3;
            3'd4:    return 4;
            3'd2:    return 5;
            3'd3:    return 6;
            default: return 0;
        endcase
    endfunction

    function automatic bit taken_of(input logic [2:0] f3, input logic z, input logic s);
        case (f3)
            3'd0:    return z;
            3'd1:    return !z;
            3'd4:    return s;
            3'd5:    return !s;
            default: return 1'b0;
        endcase
    endfunction

    // Expected cycle-by-cycle control words of one instruction, starting at fetch
    task automatic run_instr(input string name, input logic [6:0] op, input logic [2:0] f3,
                             input logic [6:0] f7, input logic z, input logic s);
        logic [17:0] q[$];
        bit legal = 1'b1;
        logic [17:0] aluwb = cw(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        q.push_back(cw(1, 0, 0, 1, 0, 2, 0, 2, 0, 0));
        q.push_back(cw(0, 0, 0, 0, 0, 0, 1, 1, 0, (op == JAL) ? 3 : 2));
        case (op)
            LW: begin
                q.push_back(cw(0, 0, 0, 0, 0, 0, 2, 1, 0, 0));
                q.push_back(cw(0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
                q.push_back(cw(0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
            end
            SW: begin
                q.push_back(cw(0, 0, 0, 0, 0, 0, 2, 1, 0, 1));
                q.push_back(cw(0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
            end
            RT: begin
                q.push_back(cw(0, 0, 0, 0, 0, 0, 2, 0, alu_of(f3, f7, 1'b1), 0));
                q.push_back(aluwb);
            end
            IT: begin
                q.push_back(cw(0, 0, 0, 0, 0, 0, 2, 1, alu_of(f3, f7, 1'b0), 0));
                q.push_back(aluwb);
            end
            BR:   q.push_back(cw(taken_of(f3, z, s), 0, 0, 0, 0, 0, 2, 0, 1, 0));
            JAL: begin
                q.push_back(cw(1, 0, 0, 0, 0, 0, 1, 2, 0, 0));
                q.push_back(aluwb);
            end
            JALR: begin
                q.push_back(cw(0, 0, 0, 0, 0, 0, 2, 1, 0, 0));
                q.push_back(cw(1, 0, 0, 0, 0, 0, 1, 2, 0, 0));
                q.push_back(aluwb);
            end
            LUI:  q.push_back(cw(0, 0, 0, 0, 1, 3, 0, 0, 0, 4));
            default: legal = 1'b0;
        endcase
        opcode = op; func3 = f3; func7 = f7; zero = z; sign = s;
        for (int i = 0; i < q.size(); i++) begin
            @(negedge clk);
            if (i == 0) check({name, " instret"}, 32'(instret), 32'(model_cnt));
            check($sformatf("%s c%0d ctrl", name, i + 1), 32'(ctrl), 32'(q[i]));
            check($sformatf("%s c%0d halt", name, i + 1), 32'(halt), 32'd0);
            @(posedge clk);
            #1;
        end
        if (legal) model_cnt = (model_cnt + 1) % (1 << CNT_W);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] ops[8];
        ops = '{LW, SW, RT, IT, BR, JAL, JALR, LUI};
        rst = 1'b0; opcode = RT; func3 = 3'd0; func7 = 7'd0; zero = 1'b0; sign = 1'b0;
        repeat (2) @(negedge clk);
        check("rst enables", 32'({PCWrite, IRWrite, RegWrite, MemWrite}), 32'd0);
        check("rst halt", 32'(halt), 32'd0);
        check("rst instret", 32'(instret), 32'd0);
        check("rst fetch srcB", 32'(ALUSrcB), 32'd2);
        @(posedge clk); #1; rst = 1'b1;

        run_instr("add",  RT,   3'd0, 7'b0000000, 1'b0, 1'b0);
        run_instr("sub",  RT,   3'd0, 7'b0100000, 1'b0, 1'b0);
        run_instr("slt",  RT,   3'd2, 7'b0000000, 1'b0, 1'b0);
        run_instr("addi", IT,   3'd0, 7'b0100000, 1'b0, 1'b0);
        run_instr("lw",   LW,   3'd2, 7'd0, 1'b0, 1'b0);
        run_instr("sw",   SW,   3'd2, 7'd0, 1'b0, 1'b0);
        run_instr("beq",  BR,   3'd0, 7'd0, 1'b1, 1'b0);
        run_instr("bne",  BR,   3'd1, 7'd0, 1'b1, 1'b0);
        run_instr("blt",  BR,   3'd4, 7'd0, 1'b0, 1'b1);
        run_instr("bge",  BR,   3'd5, 7'd0, 1'b0, 1'b1);
        run_instr("bxx",  BR,   3'd2, 7'd0, 1'b1, 1'b1);
        run_instr("jal",  JAL,  3'd0, 7'd0, 1'b0, 1'b0);
        run_instr("jalr", JALR, 3'd0, 7'd0, 1'b0, 1'b0);
        run_instr("lui",  LUI,  3'd0, 7'd0, 1'b0, 1'b0);

        for (int n = 0; n < 60; n++) begin
            run_instr($sformatf("rnd%0d", n), ops[$urandom_range(7)], 3'($urandom),
                      7'($urandom), 1'($urandom), 1'($urandom));
        end

        // Reset while a store is in its write cycle
        opcode = SW; func3 = 3'd2;
        repeat (3) begin @(posedge clk); #1; end
        #2 rst = 1'b0;
        #1;
        model_cnt = 0;
        check("rstmid memwrite", 32'(MemWrite), 32'd0);
        check("rstmid enables", 32'({PCWrite, IRWrite, RegWrite, MemWrite}), 32'd0);
        check("rstmid instret", 32'(instret), 32'd0);
        @(posedge clk); #1; rst = 1'b1;
        run_instr("post-rst add", RT, 3'd7, 7'd0, 1'b0, 1'b0);

        run_instr("illegal", 7'b1111111, 3'd0, 7'd0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            opcode = RT;
            @(negedge clk);
            check($sformatf("ill c%0d ctrl", i), 32'(ctrl), 32'd0);
            check($sformatf("ill c%0d halt", i), 32'(halt), 32'd1);
            check($sformatf("ill c%0d instret", i), 32'(instret), 32'(model_cnt));
            @(posedge clk); #1;
        end
        #2 rst = 1'b0;
        #1;
        model_cnt = 0;
        check("ill rst halt", 32'(halt), 32'd0);
        check("ill rst instret", 32'(instret), 32'd0);
        check("ill rst enables", 32'({PCWrite, IRWrite, RegWrite, MemWrite}), 32'd0);
        @(posedge clk); #1; rst = 1'b1;
        run_instr("recover lui", LUI, 3'd0, 7'd0, 1'b0, 1'b0);
        @(negedge clk);
        check("final instret", 32'(instret), 32'(model_cnt));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- FSM controller that sequences the team's multi-cycle RV32I datapath: unified instruction/data memory, IR/OldPC/A/B/ALUOut/Data registers between stages.
- Decodes opcode/func3/func7 and issues per-cycle datapath controls.
- Halts on an illegal opcode.
- Counts retired instructions.

Parameters:
- CNT_W, 32, width of retired-instruction counter

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- opcode  in  7  IR[6:0]
- func3  in  3  IR[14:12]
- func7  in  7  IR[31:25]
- zero  in  1  ALU result == 0
- sign  in  1  ALU result[31]
- PCWrite  out  1  PC register load
- AdrSrc  out  1  memory address: 0 = PC, 1 = ALUOut/Result
- MemWrite  out  1  memory write
- IRWrite  out  1  IR and OldPC load
- RegWrite  out  1  register-file write
- ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult, 11 ImmExt
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 A
- ALUSrcB  out  2  00 B, 01 ImmExt, 10 constant 4
- ALUControl  out  4  0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT, 0110 SLTU
- ImmSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U
- halt  out  1  sticky illegal-instruction flag
- instret  out  CNT_W  retired-instruction count

Behaviour:
- Reset (rst = 0, asynchronous):
  - state = FETCH, instret = 0, halt = 0.
  - PCWrite, IRWrite, RegWrite and MemWrite are forced to 0 while reset is asserted.
- Outputs are decoded from state (Moore), plus the opcode/func3 decode described below.
- Unlisted outputs are 0 in every state.
- States and actions:
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUControl=ADD, ResultSrc=10, PCWrite=1. Next state DECODE.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ADD, ImmSrc=J if opcode=1101111, else B (ALUOut = branch/jump target). Next state by opcode:
    - 0000011 -> MEMADR
    - 0100011 -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1100011 -> BRANCH
    - 1101111 -> JAL
    - 1100111 -> JALRADR
    - 0110111 -> LUI
    - any other -> ILLEGAL
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ADD, ImmSrc = I for lw, S for sw. Next state MEMREAD for lw, MEMWRITE for sw.
  - MEMREAD: ResultSrc=00, AdrSrc=1. Next state MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1. Next state FETCH.
  - MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1. Next state FETCH.
  - EXECR: ALUSrcA=10, ALUSrcB=00. ALUControl from func3/func7:
    - 000 with func7[5]=0 -> ADD; 000 with func7[5]=1 -> SUB
    - 111 -> AND, 110 -> OR, 100 -> XOR, 010 -> SLT, 011 -> SLTU
    - other func3 -> ADD
    - Next state ALUWB.
  - EXECI: ALUSrcA=10, ALUSrcB=01, ImmSrc=I. Same func3 mapping as EXECR, except 000 is always ADD. Next state ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1. Next state FETCH.
  - BRANCH: ALUSrcA=10, ALUSrcB=00, SUB, ResultSrc=00. PCWrite = taken, where:
    - func3 000 -> zero; 001 -> !zero; 100 -> sign; 101 -> !sign
    - other func3 -> taken = 0
    - Next state FETCH.
  - JALRADR: ALUSrcA=10, ALUSrcB=01, ImmSrc=I, ADD. Next state JAL.
  - JAL: ALUSrcA=01, ALUSrcB=10, ADD, ResultSrc=00, PCWrite=1 (target to PC; ALUOut captures OldPC+4). Next state ALUWB.
  - LUI: ImmSrc=U, ResultSrc=11, RegWrite=1. Next state FETCH.
  - ILLEGAL: halt=1, all write enables 0. Stays in ILLEGAL until reset.
- Latency in cycles: lui 3, beq/bne/blt/bge 3, sw 4, R-type 4, I-type 4, lw 5, jal 4, jalr 5.
- instret:
  - Increments by 1 on the clock edge leaving a terminal state: MEMWB, MEMWRITE, ALUWB, BRANCH, LUI.
  - Wraps modulo 2^CNT_W.
  - Never increments in ILLEGAL.
- Reset mid-instruction: any state returns to FETCH immediately. No MemWrite/RegWrite pulse while rst = 0.

Test Plan:
- Reset -> state FETCH, halt=0, instret=0, all write enables 0 during reset.
- Release reset, then add (opcode 0110011, func3 000, func7 0000000):
  - FETCH, DECODE, EXECR (ALUControl=0000), ALUWB (RegWrite=1)
  - instret=1 after 4 cycles
  - sub (func7 0100000) -> ALUControl=0001
- lw (0000011) -> 5 cycles, MEMREAD AdrSrc=1, MEMWB ResultSrc=01 RegWrite=1.
- sw (0100011) -> 4 cycles, MemWrite=1 only in cycle 4, ImmSrc=001.
- Branch cases:
  - beq with zero=1 -> PCWrite=1 in cycle 3
  - bne with zero=1 -> PCWrite=0
  - blt with sign=1 -> PCWrite=1
  - bge with sign=1 -> PCWrite=0
- Jumps and illegal opcode:
  - jal -> DECODE ImmSrc=011, JAL PCWrite=1, ALUWB RegWrite=1
  - jalr -> 5 cycles
  - opcode 1111111 -> ILLEGAL: halt=1, no further PCWrite/IRWrite, instret unchanged until rst=0.
